// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: field widths, control bit positions and the
// RF/EX pipeline register layout with its bubble value.
package pipe_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;

    localparam logic [3:0] NOP_OPCODE = 4'b1111;

    localparam int WB_REGWR_BIT = 0;
    localparam int MEM_RD_BIT   = 1;
    localparam int MEM_WR_BIT   = 0;
    localparam int SRC_USED_BIT = 3;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc_plus1;
        logic [2:0]        wb_ctl;
        logic [1:0]        mem_ctl;
        logic [3:0]        ex_ctl;
        logic [3:0]        opcode;
        logic [REG_AW-1:0] dest;
        logic [3:0]        src1_idx;
        logic [3:0]        src2_idx;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] imm;
        logic              valid;
    } rfex_t;

    localparam rfex_t RFEX_BUBBLE = '{
        pc:       '0,
        pc_plus1: '0,
        wb_ctl:   '0,
        mem_ctl:  '0,
        ex_ctl:   '0,
        opcode:   NOP_OPCODE,
        dest:     '0,
        src1_idx: '0,
        src2_idx: '0,
        op1:      '0,
        op2:      '0,
        imm:      '0,
        valid:    1'b0
    };

    function automatic logic [DATA_W-1:0] sext9(input logic [8:0] v);
        return {{(DATA_W-9){v[8]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
        return {{(DATA_W-6){v[5]}}, v};
    endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Architectural register file: one write port, two read ports that bypass a
// same-cycle write so a reader never sees the stale value.
module regfile_8x16
    import pipe_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd1_addr,
    input  logic [REG_AW-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1_data = (wr_en && (wr_addr == rd1_addr)) ? wr_data : regs_q[rd1_addr];
        rd2_data = (wr_en && (wr_addr == rd2_addr)) ? wr_data : regs_q[rd2_addr];
    end

endmodule

// File: rtl/rf_stage.sv
// Register-read stage: operand fetch, immediate extension, load-use hazard
// detection and the RF/EX pipeline register.
module rf_stage
    import pipe_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] pc_plus1_in,
    input  logic [2:0]        wb_ctl_in,
    input  logic [1:0]        mem_ctl_in,
    input  logic [3:0]        ex_ctl_in,
    input  logic [3:0]        opcode_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [2:0]        dest_in,
    input  logic [8:0]        imm9_in,
    input  logic [5:0]        imm6_in,
    input  logic              imm_sel_in,
    input  logic              valid_in,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] pc_plus1_out,
    output logic [2:0]        wb_ctl_out,
    output logic [1:0]        mem_ctl_out,
    output logic [3:0]        ex_ctl_out,
    output logic [3:0]        opcode_out,
    output logic [2:0]        dest_out,
    output logic [3:0]        src1_idx_out,
    output logic [3:0]        src2_idx_out,
    output logic [DATA_W-1:0] op1_out,
    output logic [DATA_W-1:0] op2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic              valid_out
);

    rfex_t             rfex_q;
    rfex_t             rfex_d;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic              load_in_ex;
    logic              src1_hit;
    logic              src2_hit;
    logic              hazard;

    regfile_8x16 u_regfile (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data),
        .rd1_addr (src1_in[REG_AW-1:0]),
        .rd2_addr (src2_in[REG_AW-1:0]),
        .rd1_data (rd1_data),
        .rd2_data (rd2_data)
    );

    // A load still in RF/EX cannot be forwarded in time, so a dependent reader waits one cycle.
    always_comb begin
        load_in_ex = rfex_q.valid & rfex_q.mem_ctl[MEM_RD_BIT] & rfex_q.wb_ctl[WB_REGWR_BIT];
        src1_hit   = src1_in[SRC_USED_BIT] & (src1_in[REG_AW-1:0] == rfex_q.dest);
        src2_hit   = src2_in[SRC_USED_BIT] & (src2_in[REG_AW-1:0] == rfex_q.dest);
        hazard     = valid_in & load_in_ex & (src1_hit | src2_hit);
        // Flush wins so the wrong-path instruction is not held in ID_RF.
        stall_out  = hazard & ~flush;
    end

    always_comb begin
        rfex_d = RFEX_BUBBLE;
        if (!flush && !stall_out && valid_in) begin
            rfex_d.pc       = pc_in;
            rfex_d.pc_plus1 = pc_plus1_in;
            rfex_d.wb_ctl   = wb_ctl_in;
            rfex_d.mem_ctl  = mem_ctl_in;
            rfex_d.ex_ctl   = ex_ctl_in;
            rfex_d.opcode   = opcode_in;
            rfex_d.dest     = dest_in;
            rfex_d.src1_idx = src1_in;
            rfex_d.src2_idx = src2_in;
            rfex_d.op1      = src1_in[SRC_USED_BIT] ? rd1_data : '0;
            rfex_d.op2      = src2_in[SRC_USED_BIT] ? rd2_data : '0;
            rfex_d.imm      = imm_sel_in ? sext9(imm9_in) : sext6(imm6_in);
            rfex_d.valid    = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rfex_q <= RFEX_BUBBLE;
        end else begin
            rfex_q <= rfex_d;
        end
    end

    always_comb begin
        pc_out       = rfex_q.pc;
        pc_plus1_out = rfex_q.pc_plus1;
        wb_ctl_out   = rfex_q.wb_ctl;
        mem_ctl_out  = rfex_q.mem_ctl;
        ex_ctl_out   = rfex_q.ex_ctl;
        opcode_out   = rfex_q.opcode;
        dest_out     = rfex_q.dest;
        src1_idx_out = rfex_q.src1_idx;
        src2_idx_out = rfex_q.src2_idx;
        op1_out      = rfex_q.op1;
        op2_out      = rfex_q.op2;
        imm_out      = rfex_q.imm;
        valid_out    = rfex_q.valid;
    end

endmodule

// File: tb/tb_rf_stage.sv
// Directed bench for rf_stage: a table of per-cycle vectors with hand-computed
// results, followed by a mid-run reset sequence.
module tb_rf_stage;

    logic        clock;
    logic        reset;
    logic [15:0] pc_in;
    logic [15:0] pc_plus1_in;
    logic [2:0]  wb_ctl_in;
    logic [1:0]  mem_ctl_in;
    logic [3:0]  ex_ctl_in;
    logic [3:0]  opcode_in;
    logic [3:0]  src1_in;
    logic [3:0]  src2_in;
    logic [2:0]  dest_in;
    logic [8:0]  imm9_in;
    logic [5:0]  imm6_in;
    logic        imm_sel_in;
    logic        valid_in;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush;
    logic        stall_out;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1_out;
    logic [2:0]  wb_ctl_out;
    logic [1:0]  mem_ctl_out;
    logic [3:0]  ex_ctl_out;
    logic [3:0]  opcode_out;
    logic [2:0]  dest_out;
    logic [3:0]  src1_idx_out;
    logic [3:0]  src2_idx_out;
    logic [15:0] op1_out;
    logic [15:0] op2_out;
    logic [15:0] imm_out;
    logic        valid_out;

    int n_checks;
    int n_pass;

    rf_stage dut (
        .clock        (clock),
        .reset        (reset),
        .pc_in        (pc_in),
        .pc_plus1_in  (pc_plus1_in),
        .wb_ctl_in    (wb_ctl_in),
        .mem_ctl_in   (mem_ctl_in),
        .ex_ctl_in    (ex_ctl_in),
        .opcode_in    (opcode_in),
        .src1_in      (src1_in),
        .src2_in      (src2_in),
        .dest_in      (dest_in),
        .imm9_in      (imm9_in),
        .imm6_in      (imm6_in),
        .imm_sel_in   (imm_sel_in),
        .valid_in     (valid_in),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .stall_out    (stall_out),
        .pc_out       (pc_out),
        .pc_plus1_out (pc_plus1_out),
        .wb_ctl_out   (wb_ctl_out),
        .mem_ctl_out  (mem_ctl_out),
        .ex_ctl_out   (ex_ctl_out),
        .opcode_out   (opcode_out),
        .dest_out     (dest_out),
        .src1_idx_out (src1_idx_out),
        .src2_idx_out (src2_idx_out),
        .op1_out      (op1_out),
        .op2_out      (op2_out),
        .imm_out      (imm_out),
        .valid_out    (valid_out)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
        logic        flush;
        logic        valid;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [2:0]  dest;
        logic [3:0]  opcode;
        logic [1:0]  mem;
        logic [2:0]  wb;
        logic        imm_sel;
        logic [8:0]  imm9;
        logic [5:0]  imm6;
        logic        exp_stall;
        logic        exp_valid;
        logic [15:0] exp_op1;
        logic [15:0] exp_op2;
        logic [15:0] exp_imm;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        pc_in = '0; pc_plus1_in = '0; wb_ctl_in = '0; mem_ctl_in = '0; ex_ctl_in = '0;
        opcode_in = '0; src1_in = '0; src2_in = '0; dest_in = '0; imm9_in = '0;
        imm6_in = '0; imm_sel_in = 1'b0; valid_in = 1'b0; wb_en = 1'b0; wb_addr = '0;
        wb_data = '0; flush = 1'b0;
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        logic [15:0] e_pc;
        v = vecs[i];
        @(negedge clock);
        pc_in       = 16'h0100 + 16'(i);
        pc_plus1_in = 16'h0101 + 16'(i);
        ex_ctl_in   = 4'(i);
        wb_en       = v.wb_en;
        wb_addr     = v.wb_addr;
        wb_data     = v.wb_data;
        flush       = v.flush;
        valid_in    = v.valid;
        src1_in     = v.src1;
        src2_in     = v.src2;
        dest_in     = v.dest;
        opcode_in   = v.opcode;
        mem_ctl_in  = v.mem;
        wb_ctl_in   = v.wb;
        imm_sel_in  = v.imm_sel;
        imm9_in     = v.imm9;
        imm6_in     = v.imm6;
        #1;
        check($sformatf("v%0d stall", i), 16'(stall_out), 16'(v.exp_stall));
        @(posedge clock);
        #1;
        e_pc = 16'h0100 + 16'(i);
        check($sformatf("v%0d valid", i), 16'(valid_out), 16'(v.exp_valid));
        check($sformatf("v%0d op1", i), op1_out, v.exp_op1);
        check($sformatf("v%0d op2", i), op2_out, v.exp_op2);
        check($sformatf("v%0d imm", i), imm_out, v.exp_imm);
        if (v.exp_valid) begin
            check($sformatf("v%0d opcode", i), 16'(opcode_out), 16'(v.opcode));
            check($sformatf("v%0d pc", i), pc_out, e_pc);
            check($sformatf("v%0d pc1", i), pc_plus1_out, e_pc + 16'd1);
            check($sformatf("v%0d ctl", i), {wb_ctl_out, mem_ctl_out, ex_ctl_out, dest_out},
                  {v.wb, v.mem, 4'(i), v.dest});
            check($sformatf("v%0d srcidx", i), {src1_idx_out, src2_idx_out}, {v.src1, v.src2});
        end else begin
            check($sformatf("v%0d opcode", i), 16'(opcode_out), 16'hF);
            check($sformatf("v%0d pc", i), pc_out, 16'h0);
            check($sformatf("v%0d ctl", i), {wb_ctl_out, mem_ctl_out, ex_ctl_out, dest_out}, 16'h0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        reset = 1'b1;

        //           wb  wa  wdata     fl vl src1     src2     dst op    mem    wb      sel imm9    imm6    st vo op1       op2       imm
        vecs[0]  = '{1, 1, 16'h1111, 0, 1, 4'b1001, 4'b1010, 5, 4'h1, 2'b00, 3'b001, 1, 9'h0FF, 6'h00, 0, 1, 16'h1111, 16'h0000, 16'h00FF};
        vecs[1]  = '{1, 2, 16'h2222, 0, 1, 4'b1001, 4'b1010, 3, 4'h2, 2'b00, 3'b001, 0, 9'h000, 6'h20, 0, 1, 16'h1111, 16'h2222, 16'hFFE0};
        vecs[2]  = '{1, 3, 16'h00A5, 0, 1, 4'b1011, 4'b0011, 1, 4'h3, 2'b00, 3'b001, 1, 9'h1F0, 6'h00, 0, 1, 16'h00A5, 16'h0000, 16'hFFF0};
        vecs[3]  = '{0, 0, 16'h0000, 0, 0, 4'b1001, 4'b1010, 2, 4'h4, 2'b10, 3'b001, 1, 9'h1FF, 6'h3F, 0, 0, 16'h0000, 16'h0000, 16'h0000};
        vecs[4]  = '{0, 0, 16'h0000, 0, 1, 4'b1011, 4'b1001, 4, 4'h8, 2'b10, 3'b001, 0, 9'h000, 6'h1F, 0, 1, 16'h00A5, 16'h1111, 16'h001F};
        vecs[5]  = '{1, 4, 16'h4444, 0, 1, 4'b0000, 4'b1100, 0, 4'h5, 2'b00, 3'b001, 1, 9'h100, 6'h00, 1, 0, 16'h0000, 16'h0000, 16'h0000};
        vecs[6]  = '{0, 0, 16'h0000, 0, 1, 4'b0000, 4'b1100, 6, 4'h5, 2'b10, 3'b001, 1, 9'h100, 6'h00, 0, 1, 16'h0000, 16'h4444, 16'hFF00};
        vecs[7]  = '{0, 0, 16'h0000, 0, 1, 4'b1000, 4'b0110, 6, 4'h6, 2'b10, 3'b001, 0, 9'h000, 6'h3F, 0, 1, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[8]  = '{1, 6, 16'h6060, 1, 1, 4'b1110, 4'b1010, 6, 4'h7, 2'b10, 3'b000, 1, 9'h0AA, 6'h00, 0, 0, 16'h0000, 16'h0000, 16'h0000};
        vecs[9]  = '{0, 0, 16'h0000, 0, 1, 4'b1110, 4'b1010, 6, 4'h7, 2'b10, 3'b000, 1, 9'h0AA, 6'h00, 0, 1, 16'h6060, 16'h2222, 16'h00AA};
        vecs[10] = '{0, 0, 16'h0000, 0, 1, 4'b1001, 4'b1110, 1, 4'h9, 2'b10, 3'b001, 0, 9'h000, 6'h1A, 0, 1, 16'h1111, 16'h6060, 16'h001A};
        vecs[11] = '{0, 0, 16'h0000, 0, 1, 4'b1001, 4'b0000, 0, 4'hA, 2'b00, 3'b000, 0, 9'h000, 6'h00, 1, 0, 16'h0000, 16'h0000, 16'h0000};
        vecs[12] = '{0, 0, 16'h0000, 0, 1, 4'b1001, 4'b0000, 0, 4'hA, 2'b00, 3'b000, 0, 9'h000, 6'h00, 0, 1, 16'h1111, 16'h0000, 16'h0000};

        repeat (2) @(posedge clock);
        #1;
        check("reset opcode", 16'(opcode_out), 16'hF);
        check("reset valid", 16'(valid_out), 16'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply_vec(i);
        end

        // Mid-run reset with a live load-use hazard on the inputs.
        @(negedge clock);
        idle_inputs();
        valid_in = 1'b1; mem_ctl_in = 2'b10; wb_ctl_in = 3'b001; dest_in = 3'd5;
        pc_in = 16'h0ABC; imm_sel_in = 1'b1; imm9_in = 9'h055;
        @(posedge clock);
        @(negedge clock);
        idle_inputs();
        valid_in = 1'b1; src1_in = 4'b1101;
        #1;
        check("pre-reset stall", 16'(stall_out), 16'h1);
        check("pre-reset pc", pc_out, 16'h0ABC);
        #1;
        reset = 1'b1;
        #1;
        check("reset stall", 16'(stall_out), 16'h0);
        check("reset valid mid", 16'(valid_out), 16'h0);
        check("reset opcode mid", 16'(opcode_out), 16'hF);
        check("reset pc mid", pc_out, 16'h0);
        check("reset imm mid", imm_out, 16'h0);
        check("reset ctl mid", {wb_ctl_out, mem_ctl_out, ex_ctl_out, dest_out}, 16'h0);
        @(negedge clock);
        reset = 1'b0;

        // Every register reads back zero after reset.
        for (int r = 0; r < 4; r++) begin
            @(negedge clock);
            idle_inputs();
            valid_in = 1'b1;
            src1_in  = {1'b1, 3'(2 * r)};
            src2_in  = {1'b1, 3'(2 * r + 1)};
            @(posedge clock);
            #1;
            check($sformatf("R%0d after reset", 2 * r), op1_out, 16'h0);
            check($sformatf("R%0d after reset", 2 * r + 1), op2_out, 16'h0);
            check($sformatf("rd%0d valid", r), 16'(valid_out), 16'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
